// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the host command receiver: frame header, parser
// states, error causes and the command codes the top level decodes.
package uart_cmd_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [2:0] {
    P_HUNT = 3'd0,
    P_CMD  = 3'd1,
    P_DHI  = 3'd2,
    P_DLO  = 3'd3,
    P_CHK  = 3'd4
  } parser_state_e;

  localparam logic [1:0] ERR_STOP = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] CMD_FAN      = 8'h01;
  localparam logic [7:0] CMD_ALARM_EN = 8'h02;
  localparam logic [7:0] CMD_TEMP_TH  = 8'h03;
  localparam logic [7:0] CMD_HUMI_TH  = 8'h04;

  function automatic logic [7:0] frame_chk(input logic [7:0] c,
                                           input logic [7:0] dhi,
                                           input logic [7:0] dlo);
    return c ^ dhi ^ dlo;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling and a small
// IDLE/START/DATA/STOP state machine producing one-cycle byte/error pulses.
module uart_byte_rx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       stop_err_o,
  output logic       line_idle_o
);

  localparam int BIT_CYC = CLK_FRE * 1_000_000 / BAUD_RATE;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          meta_q, sync_q, prev_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          wait_q, wait_d;
  logic          bv_q, bv_d;
  logic          se_q, se_d;
  logic          fall;

  assign fall = prev_q & ~sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    wait_d  = wait_q;
    bv_d    = 1'b0;
    se_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // A start bit that is high again at mid-bit is a glitch: drop it quietly.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = 3'd0;
          state_d = sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        // After a bad stop bit, hold here until the line returns high.
        if (wait_q) begin
          if (sync_q) begin
            wait_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (sync_q) begin
            bv_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            se_d   = 1'b1;
            wait_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      wait_q  <= 1'b0;
      bv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wait_q  <= wait_d;
      bv_q    <= bv_d;
      se_q    <= se_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = bv_q;
  assign stop_err_o   = se_q;
  assign line_idle_o  = (state_q == S_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// Host command receiver: parses 5-byte frames (A5, cmd, dhi, dlo, xor-chk)
// from the byte receiver and emits validated commands or error strobes.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FRE      = 50,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic [15:0] cmd_data,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int BIT_CYC = CLK_FRE * 1_000_000 / BAUD_RATE;
  localparam int TMO_CYC = TIMEOUT_BITS * BIT_CYC;
  localparam int TW      = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_M1 = TW'(TMO_CYC - 1);

  logic [7:0]    rx_byte;
  logic          byte_valid, stop_err, line_idle;

  parser_state_e pstate_q, pstate_d;
  logic [7:0]    cmd_sh_q, cmd_sh_d, dhi_q, dhi_d, dlo_q, dlo_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [15:0]   data_q, data_d;
  logic          cv_q, cv_d, fe_q, fe_d;
  logic [1:0]    ec_q, ec_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;

  uart_byte_rx #(
    .CLK_FRE   (CLK_FRE),
    .BAUD_RATE (BAUD_RATE)
  ) u_byte_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (uart_rx),
    .byte_o       (rx_byte),
    .byte_valid_o (byte_valid),
    .stop_err_o   (stop_err),
    .line_idle_o  (line_idle)
  );

  // Inter-byte gap timer: only counts while a frame is open and the line is idle.
  assign tmo_hit = (pstate_q != P_HUNT) && line_idle && !byte_valid && (tmo_q == TMO_M1);

  always_comb begin
    if (pstate_q == P_HUNT || !line_idle || byte_valid) tmo_d = '0;
    else                                                tmo_d = tmo_q + TW'(1);
  end

  always_comb begin
    pstate_d = pstate_q;
    cmd_sh_d = cmd_sh_q;
    dhi_d    = dhi_q;
    dlo_d    = dlo_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    cv_d     = 1'b0;
    fe_d     = 1'b0;
    ec_d     = ec_q;
    if (stop_err) begin
      fe_d     = 1'b1;
      ec_d     = ERR_STOP;
      pstate_d = P_HUNT;
    end else if (byte_valid) begin
      case (pstate_q)
        P_HUNT: if (rx_byte == FRAME_HDR) pstate_d = P_CMD;
        P_CMD: begin
          cmd_sh_d = rx_byte;
          pstate_d = P_DHI;
        end
        P_DHI: begin
          dhi_d    = rx_byte;
          pstate_d = P_DLO;
        end
        P_DLO: begin
          dlo_d    = rx_byte;
          pstate_d = P_CHK;
        end
        P_CHK: begin
          if (rx_byte == frame_chk(cmd_sh_q, dhi_q, dlo_q)) begin
            cmd_d  = cmd_sh_q;
            data_d = {dhi_q, dlo_q};
            cv_d   = 1'b1;
          end else begin
            fe_d = 1'b1;
            ec_d = ERR_CHK;
          end
          pstate_d = P_HUNT;
        end
        default: pstate_d = P_HUNT;
      endcase
    end else if (tmo_hit) begin
      fe_d     = 1'b1;
      ec_d     = ERR_TMO;
      pstate_d = P_HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q <= P_HUNT;
      cmd_sh_q <= 8'h00;
      dhi_q    <= 8'h00;
      dlo_q    <= 8'h00;
      cmd_q    <= 8'h00;
      data_q   <= 16'h0000;
      cv_q     <= 1'b0;
      fe_q     <= 1'b0;
      ec_q     <= 2'd0;
      tmo_q    <= '0;
    end else begin
      pstate_q <= pstate_d;
      cmd_sh_q <= cmd_sh_d;
      dhi_q    <= dhi_d;
      dlo_q    <= dlo_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      cv_q     <= cv_d;
      fe_q     <= fe_d;
      ec_q     <= ec_d;
      tmo_q    <= tmo_d;
    end
  end

  assign cmd_valid = cv_q;
  assign cmd       = cmd_q;
  assign cmd_data  = data_q;
  assign frame_err = fe_q;
  assign err_code  = ec_q;
  assign busy      = (pstate_q != P_HUNT);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx; runs at 1 Mbaud (50 clocks per bit) so the
// whole sequence, including the inter-byte timeout, stays short.
module tb_uart_cmd_rx;

  localparam int BIT  = 50;
  localparam int HALF = BIT / 2;
  localparam int TMO  = 100 * BIT;
  // cmd_valid is visible this many posedges after the start bit of the checksum
  // byte is driven: 2 sync flops + edge detect, HALF + 9 bits to stop mid-point,
  // then byte_valid and cmd_valid registers.
  localparam int LAT  = 4 + HALF + 9 * BIT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rx;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic [15:0] cmd_data;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int last_vcyc = 0;
  logic [1:0] last_code = 2'd0;
  int start_cyc = 0;
  int base_v, base_e;

  uart_cmd_rx #(
    .CLK_FRE      (50),
    .BAUD_RATE    (1_000_000),
    .TIMEOUT_BITS (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_data  (cmd_data),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  // clock / reset
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor
  always @(negedge clk) begin
    if (cmd_valid) begin
      n_valid   <= n_valid + 1;
      last_vcyc <= cyc;
    end
    if (frame_err) begin
      n_err     <= n_err + 1;
      last_code <= err_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    start_cyc = cyc;
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] dh,
                            input logic [7:0] dl, input logic [7:0] ck);
    send_byte(8'hA5, 1'b1);
    send_byte(c, 1'b1);
    send_byte(dh, 1'b1);
    send_byte(dl, 1'b1);
    send_byte(ck, 1'b1);
  endtask

  task automatic settle();
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic mark();
    base_v = n_valid;
    base_e = n_err;
  endtask

  initial begin
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_cmd",       {24'd0, cmd},       32'd0);
    check("rst_cmd_data",  {16'd0, cmd_data},  32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_err_code",  {30'd0, err_code},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    rst_n = 1'b1;
    settle();

    // basic fan command, with latency from checksum start bit
    mark();
    send_frame(8'h01, 8'h00, 8'h1E, 8'h1F);
    settle();
    check("t1_nvalid",  n_valid - base_v, 1);
    check("t1_nerr",    n_err - base_e, 0);
    check("t1_cmd",     {24'd0, cmd}, 32'h01);
    check("t1_data",    {16'd0, cmd_data}, 32'h001E);
    check("t1_latency", last_vcyc - start_cyc, LAT);

    // leading garbage must be ignored
    mark();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_frame(8'h03, 8'h01, 8'h90, 8'h92);
    settle();
    check("t2_nvalid", n_valid - base_v, 1);
    check("t2_nerr",   n_err - base_e, 0);
    check("t2_cmd",    {24'd0, cmd}, 32'h03);
    check("t2_data",   {16'd0, cmd_data}, 32'h0190);

    // header value inside a frame is plain data
    mark();
    send_frame(8'h01, 8'hA5, 8'h00, 8'hA4);
    settle();
    check("t2b_nvalid", n_valid - base_v, 1);
    check("t2b_data",   {16'd0, cmd_data}, 32'hA500);

    // bad checksum keeps the previous command
    mark();
    send_frame(8'h02, 8'h00, 8'h01, 8'h00);
    settle();
    check("t3_nerr",   n_err - base_e, 1);
    check("t3_code",   {30'd0, last_code}, 32'd2);
    check("t3_nvalid", n_valid - base_v, 0);
    check("t3_cmd",    {24'd0, cmd}, 32'h01);
    check("t3_data",   {16'd0, cmd_data}, 32'hA500);
    check("t3_busy",   {31'd0, busy}, 32'd0);

    // inter-byte timeout
    mark();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    repeat (5) @(negedge clk);
    check("t4_busy_mid", {31'd0, busy}, 32'd1);
    repeat (TMO + 2 * BIT) @(negedge clk);
    check("t4_nerr",   n_err - base_e, 1);
    check("t4_code",   {30'd0, last_code}, 32'd3);
    check("t4_busy",   {31'd0, busy}, 32'd0);
    check("t4_nvalid", n_valid - base_v, 0);
    mark();
    send_frame(8'h04, 8'h00, 8'h50, 8'h54);
    settle();
    check("t4_ok_nvalid", n_valid - base_v, 1);
    check("t4_ok_cmd",    {24'd0, cmd}, 32'h04);
    check("t4_ok_data",   {16'd0, cmd_data}, 32'h0050);

    // short glitch, then a bad stop bit mid-frame
    mark();
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (HALF - 5) @(negedge clk);
    uart_rx = 1'b1;
    settle();
    check("t5_glitch_nerr", n_err - base_e, 0);
    check("t5_glitch_busy", {31'd0, busy}, 32'd0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    settle();
    check("t5_nerr",   n_err - base_e, 1);
    check("t5_code",   {30'd0, last_code}, 32'd1);
    check("t5_busy",   {31'd0, busy}, 32'd0);
    check("t5_nvalid", n_valid - base_v, 0);

    // reset in the middle of the data_hi byte
    mark();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("t6_cmd",       {24'd0, cmd}, 32'd0);
    check("t6_data",      {16'd0, cmd_data}, 32'd0);
    check("t6_frame_err", {31'd0, frame_err}, 32'd0);
    check("t6_err_code",  {30'd0, err_code}, 32'd0);
    check("t6_busy",      {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle();
    send_frame(8'h02, 8'h00, 8'h01, 8'h03);
    settle();
    check("t6_nvalid", n_valid - base_v, 1);
    check("t6_nerr",   n_err - base_e, 0);
    check("t6_ok_cmd", {24'd0, cmd}, 32'h02);
    check("t6_ok_data", {16'd0, cmd_data}, 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
